sequence_flasher: RTL and testbench

- Transmit side of the flash-digit interface consumed by the display controller. Outputs numToFlash / noNumToFlash.
- Takes a latched sequence of up to 8 BCD digits from the game controller.
- Presents the digits one at a time, each for a speed-dependent ON period, with a blank gap between digits so repeated digits stay distinguishable.
- Signals completion to the game controller so it can arm player-input checking.

---
 rtl/sequence_flasher.sv | 138 +++++++++++++
 tb/tb_sequence_flasher.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sequence_flasher.sv
// Flashes a latched sequence of up to 8 BCD digits, one at a time, with a blank
// gap between digits. Every output is registered.
module sequence_flasher #(
  parameter int BASE_TICKS = 12500000,
  parameter int MAX_LEN    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] seqData,
  input  logic [3:0]  seqLength,
  input  logic [1:0]  speedNumber,
  output logic [3:0]  numToFlash,
  output logic        noNumToFlash,
  output logic [2:0]  flashIndex,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  spd_q, spd_d;

  logic [3:0]  num_d;
  logic        blank_d;
  logic        busy_d;
  logic        done_d;
  logic [3:0]  clamped_len;

  function automatic logic [31:0] on_ticks(input logic [1:0] s);
    return 32'(BASE_TICKS) * (32'd4 - 32'(s));
  endfunction

  function automatic logic [31:0] gap_ticks(input logic [1:0] s);
    logic [31:0] half;
    half = on_ticks(s) >> 1;
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

  assign clamped_len = (seqLength > 4'(MAX_LEN)) ? 4'(MAX_LEN) : seqLength;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    data_d  = data_q;
    spd_d   = spd_q;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            data_d = seqData;
            len_d  = clamped_len;
            spd_d  = speedNumber;
            idx_d  = '0;
            if (clamped_len != 4'd0) begin
              state_d = SHOW;
              cnt_d   = on_ticks(speedNumber) - 32'd1;
            end else begin
              state_d = DONE;
            end
          end
        end
        SHOW: begin
          if (cnt_q == 32'd0) begin
            if ({1'b0, idx_q} == len_q - 4'd1) begin
              state_d = DONE;
            end else begin
              state_d = GAP;
              cnt_d   = gap_ticks(spd_q) - 32'd1;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        GAP: begin
          if (cnt_q == 32'd0) begin
            state_d = SHOW;
            idx_d   = idx_q + 3'd1;
            cnt_d   = on_ticks(spd_q) - 32'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    blank_d = (state_d != SHOW);
    num_d   = blank_d ? 4'd0 : data_d[{idx_d, 2'b00} +: 4];
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      data_q       <= '0;
      spd_q        <= '0;
      numToFlash   <= '0;
      noNumToFlash <= 1'b1;
      flashIndex   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      data_q       <= data_d;
      spd_q        <= spd_d;
      numToFlash   <= num_d;
      noNumToFlash <= blank_d;
      flashIndex   <= idx_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_sequence_flasher.sv
// Directed bench for sequence_flasher with BASE_TICKS = 4 (on = 16/12/8/4, gap = 8/6/4/2).
module tb_sequence_flasher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] seqData;
  logic [3:0]  seqLength;
  logic [1:0]  speedNumber;
  logic [3:0]  numToFlash;
  logic        noNumToFlash;
  logic [2:0]  flashIndex;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  sequence_flasher #(.BASE_TICKS(4), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .seqData(seqData), .seqLength(seqLength), .speedNumber(speedNumber),
    .numToFlash(numToFlash), .noNumToFlash(noNumToFlash), .flashIndex(flashIndex),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  spd;
    int          inject_at;  // sample number at which a stray start is pulsed, 0 = none
    int          exp_busy;
    int          exp_vis;
    int          exp_shows;
    int          exp_idx;
    int          exp_sum;
    int          exp_first;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, ".blank"}, 32'(noNumToFlash), 32'd1);
    check({name, ".num"},   32'(numToFlash),   32'd0);
    check({name, ".busy"},  32'(busy),         32'd0);
    check({name, ".done"},  32'(done),         32'd0);
  endtask

  task automatic run_vector(input vec_t v);
    int cyc = 0, vis = 0, shows = 0, sum = 0, max_idx = 0, dones = 0;
    int first = -1;
    logic prev_blank = 1'b1;
    start = 1'b1; seqData = v.data; seqLength = v.len; speedNumber = v.spd;
    step();
    start = 1'b0; seqData = 32'hDEAD_BEEF; seqLength = 4'd5; speedNumber = 2'd0;
    first = int'(numToFlash);
    while (busy === 1'b1 && cyc < 300) begin
      cyc++;
      if (noNumToFlash === 1'b0) begin
        vis++;
        sum += int'(numToFlash);
        if (prev_blank) shows++;
      end
      prev_blank = noNumToFlash;
      if (int'(flashIndex) > max_idx) max_idx = int'(flashIndex);
      if (done === 1'b1) dones++;
      if (cyc == v.inject_at) begin
        start = 1'b1; seqData = 32'hF; seqLength = 4'd1; speedNumber = 2'd0;
      end
      step();
      start = 1'b0;
    end
    check({v.name, ".timeout"}, 32'(cyc < 300), 32'd1);
    check({v.name, ".first"},   32'(first),     32'(v.exp_first));
    check({v.name, ".busy"},    32'(cyc),       32'(v.exp_busy));
    check({v.name, ".vis"},     32'(vis),       32'(v.exp_vis));
    check({v.name, ".shows"},   32'(shows),     32'(v.exp_shows));
    check({v.name, ".idx"},     32'(max_idx),   32'(v.exp_idx));
    check({v.name, ".sum"},     32'(sum),       32'(v.exp_sum));
    check({v.name, ".dones"},   32'(dones),     32'd1);
    check_idle({v.name, ".after"});
  endtask

  vec_t vecs[7];

  initial begin
    int dones;
    vecs[0] = '{"rep559",  32'h0000_0955, 4'd3,  2'd3, 0, 17, 12, 3, 2, 76,  5};
    vecs[1] = '{"slow7",   32'h0000_0007, 4'd1,  2'd0, 0, 17, 16, 1, 0, 112, 7};
    vecs[2] = '{"len0",    32'h0000_0001, 4'd0,  2'd2, 0, 1,  0,  0, 0, 0,   0};
    vecs[3] = '{"len12",   32'h7654_3210, 4'd12, 2'd3, 0, 47, 32, 8, 7, 112, 0};
    vecs[4] = '{"hexAF",   32'h0000_00FA, 4'd2,  2'd1, 0, 31, 24, 2, 1, 300, 10};
    vecs[5] = '{"rep33",   32'h0000_0033, 4'd2,  2'd2, 0, 21, 16, 2, 1, 48,  3};
    vecs[6] = '{"ignstart",32'h0000_0955, 4'd3,  2'd3, 5, 17, 12, 3, 2, 76,  5};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    seqData = '0; seqLength = '0; speedNumber = '0;
    step(); step();
    check_idle("reset");
    check("reset.idx", 32'(flashIndex), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_vector(vecs[i]);
      step();
    end

    // Abort during the second digit of 1,2,3,4 at speed 3: samples 7..10 show digit 2.
    start = 1'b1; seqData = 32'h0000_4321; seqLength = 4'd4; speedNumber = 2'd3;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    check("abort.pre_num", 32'(numToFlash), 32'd2);
    check("abort.pre_idx", 32'(flashIndex), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort.post");
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("abort.quiet", 32'(dones), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("replay.num",   32'(numToFlash),   32'd1);
    check("replay.idx",   32'(flashIndex),   32'd0);
    check("replay.blank", 32'(noNumToFlash), 32'd0);

    // Synchronous reset mid-run.
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst.idx", 32'(flashIndex), 32'd0);
    step();

    // Start and abort together from IDLE: the run must not begin.
    start = 1'b1; abort = 1'b1; seqData = 32'h0000_0088; seqLength = 4'd2; speedNumber = 2'd3;
    step();
    start = 1'b0; abort = 1'b0;
    check_idle("startabort");
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (busy === 1'b1 || noNumToFlash !== 1'b1) dones++;
    end
    check("startabort.quiet", 32'(dones), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
